comparer_seq: RTL
=================

# comparer_seq

Multi-cycle, parametrised magnitude comparator for the bb_core ALU. It replaces the single-cycle combinational compare for wide operands. Each operand pair is compared chunk by chunk, starting at the most-significant chunk, with early termination on the first unequal chunk. It supports signed and unsigned modes and uses a valid/ready handshake on both input and output. It returns the standard relation codes (LT/EQ/GT) zero-extended to DATA_WIDTH.

## Interface
- DATA_WIDTH, 32: operand and result width. Must be >= 8 and a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 8: bits compared per cycle. NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_clear  in  1  synchronous abort of any operation in flight.
- i_valid  in  1  operand pair offered.
- o_ready  out  1  comparer can accept an operand pair this cycle.
- i_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled on accept.
- i_data0  in  DATA_WIDTH  left operand; sampled on accept.
- i_data1  in  DATA_WIDTH  right operand; sampled on accept.
- o_valid  out  1  result available.
- i_ready  in  1  consumer takes the result this cycle.
- o_relation  out  DATA_WIDTH  relation code of data0 vs data1:
  - 'h3C when data0 < data1
  - 'h3D when data0 == data1
  - 'h3E when data0 > data1

## Operation
- States:
  - IDLE: reset state.
  - CMP: chunk iteration.
  - DONE: result held.
- Accept = i_valid && o_ready && !i_clear. On accept:
  - latch both operands and the mode;
  - in signed mode, invert bit DATA_WIDTH-1 of both latched operands, so the compare is unsigned from then on;
  - load the chunk index with NCHUNK-1;
  - go to CMP.
- CMP, each cycle: compare chunk [idx*CHUNK_WIDTH +: CHUNK_WIDTH] of both operands, unsigned.
  - Chunks unequal: register LT or GT, go to DONE.
  - Chunks equal and idx == 0: register EQ, go to DONE.
  - Chunks equal and idx > 0: decrement idx, stay in CMP.
- DONE: o_valid = 1 and the result is held stable until i_ready.
  - i_ready without a new accept: go to IDLE.
- o_ready = !i_clear && (state == IDLE || (state == DONE && i_ready)).
  - Accept in the same cycle as a result handoff: go straight to CMP with the new operands (back-to-back, no bubble).
- o_relation drives 0 whenever o_valid = 0.
- Upper bits of o_relation (DATA_WIDTH-1:8) are always 0.
- i_clear: from any state, go to IDLE on the next edge. o_valid drops and the pending result is discarded. Clear wins over a simultaneous accept or handoff.
- Asynchronous rst mid-operation: immediately go to IDLE. Operands and index are cleared.

## Timing
- Reset values:
  - o_valid = 0
  - o_ready = 1 (when i_clear = 0)
  - o_relation = 0
  - state = IDLE
  - chunk index = 0
- Latency from the accept edge to o_valid = k+1 cycles, where k is the number of leading equal chunks.
  - Minimum 1 cycle (MSB chunk differs).
  - Maximum NCHUNK cycles (equal operands, or only the LSB chunk differs).
- Throughput: one result per latency cycle when the consumer holds i_ready = 1 and the producer holds i_valid = 1.
- o_ready depends combinationally on i_ready and i_clear. o_valid and o_relation are register outputs.
- Input operands need not be held after the accept edge.

## Structure
- Shared define header:
  - relation constants REL_LT = 'h3C, REL_EQ = 'h3D, REL_GT = 'h3E;
  - state encodings IDLE/CMP/DONE;
  - DATA_WIDTH default.
- One sub-module, cmp_chunk: purely combinational, CHUNK_WIDTH-parametrised. Outputs lt, eq and gt for one chunk pair. It is instantiated once and driven through the indexed part-select mux.
- The FSM, operand registers, index counter and result register live in comparer_seq.

## Test plan
- Reset: assert rst asynchronously mid-cycle with no clock edge. Required response: o_valid = 0, o_ready = 1 and o_relation = 0 immediately.
- Unsigned, 32/8: 0x12345678 vs 0x12345679. Required response: o_relation = 0x3C with o_valid 4 cycles after accept. 0xDEADBEEF vs 0xDEADBEEF gives 0x3D after 4 cycles.
- Mode, MSB chunk differs: 0x80000000 vs 0x00000001. Unsigned gives 0x3E after 1 cycle; signed gives 0x3C after 1 cycle. 0xFFFFFFFF vs 0xFFFFFFFE signed gives 0x3E after 4 cycles.
- Back-pressure:
  - Hold i_ready = 0 for 3 cycles after o_valid. o_relation stays stable, o_ready stays 0, and a new i_valid is not accepted.
  - Raising i_ready with i_valid = 1 hands off and accepts in the same cycle. The next result follows with no idle cycle.
- Abort: pulse i_clear on the 2nd CMP cycle of 0x11223344 vs 0x11223355. o_valid never rises and o_ready = 1 on the following cycle. i_clear together with i_valid produces no accept.
- Random: 10k random pairs with random mode, i_valid, i_ready and rare i_clear, checked against a reference model. Also cover parameter sets 32/8, 64/16, 8/8 (single chunk, latency 1) and 32/1.

Source files
------------

// File: rtl/comparer_seq_pkg.sv
// Shared constants for the chunked magnitude comparator: relation codes,
// FSM state encoding and the default operand width.
package comparer_seq_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [7:0] REL_LT = 8'h3C;
    localparam logic [7:0] REL_EQ = 8'h3D;
    localparam logic [7:0] REL_GT = 8'h3E;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comparer_seq_cmp_chunk.sv
// Combinational unsigned compare of one chunk pair; exactly one output is high.
module cmp_chunk #(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] i_a,
    input  logic [CHUNK_WIDTH-1:0] i_b,
    output logic                   o_lt,
    output logic                   o_eq,
    output logic                   o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/comparer_seq.sv
// Multi-cycle magnitude comparator: walks operand chunks from the MSB end and
// stops at the first unequal chunk; valid/ready on both sides.
module comparer_seq
    import comparer_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_signed,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_relation
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_op0;
    logic [DATA_WIDTH-1:0]   r_op1;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_valid;
    logic [7:0]              r_rel;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_signMask;
    logic [CHUNK_WIDTH-1:0]  w_chunk0;
    logic [CHUNK_WIDTH-1:0]  w_chunk1;
    logic                    w_lt;
    logic                    w_eq;
    logic                    w_gt;

    assign o_ready  = !i_clear && (r_state == ST_IDLE || (r_state == ST_DONE && i_ready));
    assign w_accept = i_valid && o_ready;

    // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
    assign w_signMask = {i_signed, {(DATA_WIDTH-1){1'b0}}};

    assign w_chunk0 = r_op0[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];
    assign w_chunk1 = r_op1[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];

    cmp_chunk #(
        .CHUNK_WIDTH (CHUNK_WIDTH)
    ) u_cmp_chunk (
        .i_a  (w_chunk0),
        .i_b  (w_chunk1),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    assign o_valid    = r_valid;
    assign o_relation = DATA_WIDTH'(r_rel);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op0   <= '0;
            r_op1   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_rel   <= '0;
        end else if (i_clear) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_rel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op0   <= i_data0 ^ w_signMask;
                        r_op1   <= i_data1 ^ w_signMask;
                        r_idx   <= IDX_TOP;
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (w_lt) begin
                        r_rel   <= REL_LT;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_gt) begin
                        r_rel   <= REL_GT;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_eq && r_idx == '0) begin
                        r_rel   <= REL_EQ;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    // A handoff may coincide with a new accept, giving back-to-back results.
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_rel   <= '0;
                        if (w_accept) begin
                            r_op0   <= i_data0 ^ w_signMask;
                            r_op1   <= i_data1 ^ w_signMask;
                            r_idx   <= IDX_TOP;
                            r_state <= ST_CMP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
